mrx_prmb_sync: RTL and testbench
================================

Name: mrx_prmb_sync

Overview:
Receive-side companion to the multi-tone localisation transmitter. Consumes baseband IQ from the radio and recovers the ±16384 BPSK preamble with integrate-and-dump at PRMB_OS samples per bit. It detects the preamble tail sync word, skips the idle gap, then gates exactly NCAP tone samples to the downstream FFT/phase estimator. Coarse bit timing is found by periodic sample slipping.

Parameters:
DATA_WIDTH, 16, I/Q sample width (two's complement)
PRMB_OS, 128, samples per preamble bit
SYNC_LEN, 32, sync-word length in bits (last SYNC_LEN preamble bits)
SYNC_WORD, 32'h0000_0000, expected bits; MSB = oldest bit; set from preamble file tail
MAX_ERR, 3, max Hamming distance accepted as a match
SLIP_PERIOD, 64, dumps without match before a timing slip
SLIP, 32, accepted beats discarded per slip
NIDLE_SAMPS, 32768, accepted beats skipped after match (TX idle gap)
NCAP, 32768, tone beats forwarded per capture

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
clear  in  1  synchronous abort to ACQ, same effect as reset except slip_count is kept
in_tdata  in  2*DATA_WIDTH  {i,q} sample
in_tvalid  in  1  sample strobe; no backpressure
out_tdata  out  2*DATA_WIDTH  captured {i,q}
out_tvalid  out  1  captured sample valid
out_tlast  out  1  last captured sample
sync_pulse  out  1  one-cycle pulse on sync-word match
rx_state  out  2  ACQ=0, SLIP=1, WAIT=2, CAPTURE=3
err_count  out  $clog2(SYNC_LEN+1)  Hamming distance at most recent dump
slip_count  out  8  slips since reset, wraps at 255

Behaviour:
- Reset values:
  - All outputs 0; state ACQ.
  - Accumulator, sample/dump/fill/beat counters and shift register all 0.
- Beat definition: all counters advance only on in_tvalid=1 ("beat"). in_tvalid=0 freezes everything except output registers, which drop out_tvalid.
- ACQ:
  - Each beat adds sext(i)+sext(q) into an accumulator of width DATA_WIDTH+1+$clog2(PRMB_OS).
  - On beat number PRMB_OS-1 ("dump beat"):
    - bit = (final sum >= 0);
    - shift_next = {shift[SYNC_LEN-2:0], bit};
    - accumulator restarts with the next beat;
    - fill counter saturates at SYNC_LEN;
    - err_count <= popcount(shift_next ^ SYNC_WORD).
  - Match = fill (including this bit) >= SYNC_LEN and popcount <= MAX_ERR. Popcount is combinational in the dump cycle.
  - On match: next state WAIT; sync_pulse=1 in the following cycle only.
  - On no match: the dump counter increments. When it reaches SLIP_PERIOD, go to SLIP and clear the dump counter.
- SLIP:
  - Discard SLIP beats; slip_count +1 on entry.
  - Then return to ACQ with the accumulator cleared and fill=0. Shift register contents are retained but ignored until refilled.
- WAIT: count NIDLE_SAMPS beats after the dump beat, then go to CAPTURE. The first CAPTURE beat is dump beat + NIDLE_SAMPS + 1.
- CAPTURE:
  - Each beat is registered to out_tdata with out_tvalid=1, latency 1 clk.
  - out_tlast=1 with the NCAP-th beat.
  - After the NCAP-th beat, go to ACQ with all counters cleared.
- clear / reset during any state: abort immediately and discard any partial capture. out_tvalid and out_tlast go 0 next cycle, with no tlast emitted.
- clear and a dump beat in the same cycle: clear wins, and no sync_pulse is issued.
- Sum at exactly 0 decodes as bit 1.
- Accumulator cannot overflow by construction of its width.

Decomposition:
- Package mrx_pkg:
  - state encoding localparams;
  - function acc_width(DATA_WIDTH, PRMB_OS);
  - popcount function.
- Sub-module mrx_int_dump: the accumulator and sample counter. Inputs: sample, valid, restart. Outputs: dump strobe, hard bit. It is instantiated once.

Test Plan:
- Aligned preamble: TX sync word, PRMB_OS=128, ideal ±16384 on I=Q -> sync_pulse exactly 1 clk after the dump beat of the last sync bit; err_count=0; no slip.
- Bit errors: flip 3 sync-word bits -> match with err_count=3. Flip 4 bits -> no match; after 64 dumps rx_state=SLIP and slip_count=1.
- Misalignment: preamble delayed 64 samples (half-bit) -> lock within 2 slips; tone capture then starts at dump beat+32769.
- Capture framing: NIDLE_SAMPS=16, NCAP=8, ramp data with random in_tvalid gaps -> exactly 8 out_tvalid beats, out_tlast on the 8th, data equal to input beats 17..24 after the dump, then rx_state=ACQ.
- Abort: assert clear during CAPTURE beat 4 of 8 -> out_tvalid=0 next cycle, no tlast, rx_state=ACQ, slip_count unchanged.
- Noise only: random samples for 10^6 beats with MAX_ERR=0 -> no sync_pulse, and slip_count equals the number of elapsed slip periods mod 256.

Source files
------------

// File: rtl/mrx_pkg.sv
// Shared definitions for the preamble synchroniser: state encoding and
// helpers that size the integrator and score sync-word matches.
package mrx_pkg;

    localparam logic [1:0] RX_ACQ     = 2'd0;
    localparam logic [1:0] RX_SLIP    = 2'd1;
    localparam logic [1:0] RX_WAIT    = 2'd2;
    localparam logic [1:0] RX_CAPTURE = 2'd3;

    typedef enum logic [1:0] {
        ST_ACQ     = RX_ACQ,
        ST_SLIP    = RX_SLIP,
        ST_WAIT    = RX_WAIT,
        ST_CAPTURE = RX_CAPTURE
    } rx_state_t;

    // Widest sync word the popcount helper can score.
    localparam int POPCNT_MAX = 64;

    function automatic int acc_width(input int data_width, input int prmb_os);
        return data_width + 1 + $clog2(prmb_os);
    endfunction

    function automatic int popcount(input logic [POPCNT_MAX-1:0] v);
        int n = 0;
        for (int k = 0; k < POPCNT_MAX; k++) begin
            n += int'(v[k]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mrx_prmb_sync_if.sv
// IQ stream into the synchroniser and gated capture stream out of it.
interface mrx_prmb_sync_if #(
    parameter int DATA_WIDTH = 16
);
    logic [2*DATA_WIDTH-1:0] in_tdata;
    logic                    in_tvalid;
    logic [2*DATA_WIDTH-1:0] out_tdata;
    logic                    out_tvalid;
    logic                    out_tlast;

    modport master (
        output in_tdata, in_tvalid,
        input  out_tdata, out_tvalid, out_tlast
    );

    modport slave (
        input  in_tdata, in_tvalid,
        output out_tdata, out_tvalid, out_tlast
    );
endinterface

// File: rtl/mrx_int_dump.sv
// Integrate-and-dump over PRMB_OS beats of i+q; hard bit and dump strobe
// are combinational in the dump beat.
module mrx_int_dump
    import mrx_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PRMB_OS    = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    restart,
    input  logic [2*DATA_WIDTH-1:0] sample,
    input  logic                    valid,
    output logic                    dump,
    output logic                    hard_bit
);
    localparam int AW = acc_width(DATA_WIDTH, PRMB_OS);
    localparam int CW = $clog2(PRMB_OS);

    logic signed [AW-1:0] acc_reg, acc_next, sum, i_ext, q_ext;
    logic [CW-1:0]        cnt_reg, cnt_next;

    assign i_ext = {{(AW-DATA_WIDTH){sample[2*DATA_WIDTH-1]}}, sample[2*DATA_WIDTH-1:DATA_WIDTH]};
    assign q_ext = {{(AW-DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample[DATA_WIDTH-1:0]};
    assign sum      = acc_reg + i_ext + q_ext;
    assign dump     = valid && (cnt_reg == CW'(PRMB_OS-1));
    // A sum of exactly zero decodes as 1.
    assign hard_bit = ~sum[AW-1];

    always_comb begin
        acc_next = acc_reg;
        cnt_next = cnt_reg;
        if (restart) begin
            acc_next = '0;
            cnt_next = '0;
        end else if (valid) begin
            if (dump) begin
                acc_next = '0;
                cnt_next = '0;
            end else begin
                acc_next = sum;
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
        end
    end
endmodule

// File: rtl/mrx_prmb_sync.sv
// Preamble sync-word detector with timing slip, idle-gap skip and
// fixed-length tone capture gating.
module mrx_prmb_sync
    import mrx_pkg::*;
#(
    parameter int                  DATA_WIDTH  = 16,
    parameter int                  PRMB_OS     = 128,
    parameter int                  SYNC_LEN    = 32,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD   = '0,
    parameter int                  MAX_ERR     = 3,
    parameter int                  SLIP_PERIOD = 64,
    parameter int                  SLIP        = 32,
    parameter int                  NIDLE_SAMPS = 32768,
    parameter int                  NCAP        = 32768
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    mrx_prmb_sync_if.slave                bus,
    output logic                          sync_pulse,
    output logic [1:0]                    rx_state,
    output logic [$clog2(SYNC_LEN+1)-1:0] err_count,
    output logic [7:0]                    slip_count
);
    localparam int EW       = $clog2(SYNC_LEN+1);
    localparam int DCW      = $clog2(SLIP_PERIOD+1);
    localparam int BEAT_MAX = (SLIP > NIDLE_SAMPS) ? ((SLIP > NCAP) ? SLIP : NCAP)
                                                   : ((NIDLE_SAMPS > NCAP) ? NIDLE_SAMPS : NCAP);
    localparam int BW       = $clog2(BEAT_MAX+1);

    rx_state_t               state_reg, state_next;
    logic [SYNC_LEN-1:0]     shift_reg, shift_next, shift_cand, diff;
    logic [EW-1:0]           fill_reg, fill_next, fill_cand, err_reg, err_next;
    logic [DCW-1:0]          dumps_reg, dumps_next;
    logic [BW-1:0]           beat_reg, beat_next;
    logic [7:0]              slip_reg, slip_next;
    logic                    sync_reg, sync_next, tvalid_reg, tvalid_next, tlast_reg, tlast_next;
    logic [2*DATA_WIDTH-1:0] tdata_reg, tdata_next;
    logic                    restart, acq_beat, dump, hard_bit, match;
    int                      pc;

    assign acq_beat = bus.in_tvalid && (state_reg == ST_ACQ);

    mrx_int_dump #(
        .DATA_WIDTH(DATA_WIDTH),
        .PRMB_OS   (PRMB_OS)
    ) u_int_dump (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .sample  (bus.in_tdata),
        .valid   (acq_beat),
        .dump    (dump),
        .hard_bit(hard_bit)
    );

    // Candidate window includes the bit being decided this cycle.
    assign shift_cand = {shift_reg[SYNC_LEN-2:0], hard_bit};
    generate
        for (genvar gi = 0; gi < SYNC_LEN; gi++) begin : g_diff
            assign diff[gi] = shift_cand[gi] ^ SYNC_WORD[gi];
        end
    endgenerate
    assign pc        = popcount(POPCNT_MAX'(diff));
    assign fill_cand = (fill_reg == EW'(SYNC_LEN)) ? fill_reg : fill_reg + 1'b1;
    assign match     = (fill_cand == EW'(SYNC_LEN)) && (pc <= MAX_ERR);

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        fill_next   = fill_reg;
        dumps_next  = dumps_reg;
        beat_next   = beat_reg;
        err_next    = err_reg;
        slip_next   = slip_reg;
        tdata_next  = tdata_reg;
        sync_next   = 1'b0;
        tvalid_next = 1'b0;
        tlast_next  = 1'b0;
        restart     = 1'b0;
        if (clear) begin
            // Abort wins over everything else, including a coincident dump.
            state_next = ST_ACQ;
            shift_next = '0;
            fill_next  = '0;
            dumps_next = '0;
            beat_next  = '0;
            err_next   = '0;
            tdata_next = '0;
            restart    = 1'b1;
        end else if (bus.in_tvalid) begin
            case (state_reg)
                ST_ACQ: begin
                    if (dump) begin
                        shift_next = shift_cand;
                        fill_next  = fill_cand;
                        err_next   = EW'(pc);
                        if (match) begin
                            state_next = ST_WAIT;
                            sync_next  = 1'b1;
                            dumps_next = '0;
                            beat_next  = '0;
                        end else if (dumps_reg == DCW'(SLIP_PERIOD-1)) begin
                            state_next = ST_SLIP;
                            dumps_next = '0;
                            beat_next  = '0;
                            slip_next  = slip_reg + 8'd1;
                        end else begin
                            dumps_next = dumps_reg + 1'b1;
                        end
                    end
                end
                ST_SLIP: begin
                    if (beat_reg == BW'(SLIP-1)) begin
                        state_next = ST_ACQ;
                        beat_next  = '0;
                        fill_next  = '0;
                        restart    = 1'b1;
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (beat_reg == BW'(NIDLE_SAMPS-1)) begin
                        state_next = ST_CAPTURE;
                        beat_next  = '0;
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    tdata_next  = bus.in_tdata;
                    tvalid_next = 1'b1;
                    if (beat_reg == BW'(NCAP-1)) begin
                        tlast_next = 1'b1;
                        state_next = ST_ACQ;
                        beat_next  = '0;
                        fill_next  = '0;
                        dumps_next = '0;
                        restart    = 1'b1;
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end
                default: state_next = ST_ACQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_ACQ;
            shift_reg  <= '0;
            fill_reg   <= '0;
            dumps_reg  <= '0;
            beat_reg   <= '0;
            err_reg    <= '0;
            slip_reg   <= '0;
            sync_reg   <= 1'b0;
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            fill_reg   <= fill_next;
            dumps_reg  <= dumps_next;
            beat_reg   <= beat_next;
            err_reg    <= err_next;
            slip_reg   <= slip_next;
            sync_reg   <= sync_next;
            tdata_reg  <= tdata_next;
            tvalid_reg <= tvalid_next;
            tlast_reg  <= tlast_next;
        end
    end

    assign bus.out_tdata  = tdata_reg;
    assign bus.out_tvalid = tvalid_reg;
    assign bus.out_tlast  = tlast_reg;
    assign sync_pulse     = sync_reg;
    assign rx_state       = state_reg;
    assign err_count      = err_reg;
    assign slip_count     = slip_reg;
endmodule

// File: tb/tb_mrx_prmb_sync.sv
// Randomised bench for mrx_prmb_sync with a beat-level behavioural model
// and literal checkpoints for each scenario.
module tb_mrx_prmb_sync;
    localparam int          DW     = 16;
    localparam int          OS     = 8;
    localparam int          SL     = 8;
    localparam logic [7:0]  SW     = 8'hB4;
    localparam int          MAXE   = 1;
    localparam int          SPER   = 12;
    localparam int          NSLIP  = 2;
    localparam int          NIDLE  = 16;
    localparam int          NCAPT  = 8;
    localparam int          A      = 16384;

    logic       clk = 1'b0;
    logic       reset, clear;
    logic       sync_pulse;
    logic [1:0] rx_state;
    logic [3:0] err_count;
    logic [7:0] slip_count;

    mrx_prmb_sync_if #(.DATA_WIDTH(DW)) bus();

    mrx_prmb_sync #(
        .DATA_WIDTH(DW), .PRMB_OS(OS), .SYNC_LEN(SL), .SYNC_WORD(SW),
        .MAX_ERR(MAXE), .SLIP_PERIOD(SPER), .SLIP(NSLIP),
        .NIDLE_SAMPS(NIDLE), .NCAP(NCAPT)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus),
        .sync_pulse(sync_pulse), .rx_state(rx_state),
        .err_count(err_count), .slip_count(slip_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 acquire, 1 slip, 2 idle gap, 3 capture.
    int          m_mode, m_cnt, m_fill, m_dumps, m_n;
    longint      m_sum;
    int          m_hist[$];
    int          e_state, e_err, e_slip, e_sync, e_tv, e_tl;
    logic [31:0] e_td;

    int          beat_no, sync_seen, sync_beat, tv_seen, tl_seen, tl_at;
    logic [31:0] first_td, last_td;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(input bit keep_slip);
        m_mode = 0; m_cnt = 0; m_fill = 0; m_dumps = 0; m_n = 0; m_sum = 0;
        m_hist.delete();
        for (int k = 0; k < SL; k++) m_hist.push_back(0);
        e_err = 0; e_sync = 0; e_tv = 0; e_tl = 0; e_td = '0; e_state = 0;
        if (!keep_slip) e_slip = 0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] d, input logic clr);
        logic signed [DW-1:0] si, sq;
        int bit_v, errs;
        e_sync = 0; e_tv = 0; e_tl = 0;
        if (clr) begin
            model_clear(1);
            return;
        end
        if (v) begin
            case (m_mode)
                0: begin
                    si = d[31:16];
                    sq = d[15:0];
                    m_sum += longint'(si) + longint'(sq);
                    m_n++;
                    if (m_n == OS) begin
                        bit_v = (m_sum >= 0) ? 1 : 0;
                        m_sum = 0;
                        m_n   = 0;
                        m_hist.push_back(bit_v);
                        void'(m_hist.pop_front());
                        if (m_fill < SL) m_fill++;
                        errs = 0;
                        for (int k = 0; k < SL; k++)
                            if (m_hist[k] != int'(SW[SL-1-k])) errs++;
                        e_err = errs;
                        if (m_fill == SL && errs <= MAXE) begin
                            e_sync = 1; m_mode = 2; m_cnt = 0; m_dumps = 0;
                        end else begin
                            m_dumps++;
                            if (m_dumps == SPER) begin
                                m_mode = 1; m_dumps = 0; m_cnt = 0;
                                e_slip = (e_slip + 1) % 256;
                            end
                        end
                    end
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == NSLIP) begin m_mode = 0; m_cnt = 0; m_fill = 0; end
                end
                2: begin
                    m_cnt++;
                    if (m_cnt == NIDLE) begin m_mode = 3; m_cnt = 0; end
                end
                default: begin
                    m_cnt++;
                    e_tv = 1;
                    e_td = d;
                    e_tl = (m_cnt == NCAPT) ? 1 : 0;
                    if (m_cnt == NCAPT) begin m_mode = 0; m_cnt = 0; m_fill = 0; m_dumps = 0; end
                end
            endcase
        end
        e_state = m_mode;
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic clr);
        bus.in_tvalid = v;
        bus.in_tdata  = d;
        clear         = clr;
        model_step(v, d, clr);
        @(posedge clk);
        #1;
        if (v && !clr) beat_no++;
        chk("rx_state", rx_state, e_state);
        chk("err_count", err_count, e_err);
        chk("slip_count", slip_count, e_slip);
        chk("sync_pulse", sync_pulse, e_sync);
        chk("out_tvalid", bus.out_tvalid, e_tv);
        chk("out_tlast", bus.out_tlast, e_tl);
        if (e_tv != 0) chk("out_tdata", bus.out_tdata, e_td);
        if (sync_pulse) begin
            sync_seen++;
            sync_beat = beat_no;
            $display("sync at beat %0d err %0d slips %0d", beat_no, err_count, slip_count);
        end
        if (bus.out_tvalid) begin
            if (tv_seen == 0) first_td = bus.out_tdata;
            last_td = bus.out_tdata;
            tv_seen++;
            if (bus.out_tlast) tl_at = tv_seen;
            $display("capture beat %0d data %08h last %0b", tv_seen, bus.out_tdata, bus.out_tlast);
        end
        if (bus.out_tlast) tl_seen++;
    endtask

    function automatic logic [31:0] iq(input int i, input int q);
        logic [15:0] a, b;
        a = 16'(i);
        b = 16'(q);
        return {a, b};
    endfunction

    task automatic send_beat(input logic [31:0] d);
        if ($urandom_range(3) == 0) cycle(1'b0, $urandom, 1'b0);
        cycle(1'b1, d, 1'b0);
    endtask

    // variant 0: ideal +-A on I=Q; variant 1: ones as zero-sum, zeros at full negative scale
    task automatic send_bit(input int b, input int variant);
        for (int k = 0; k < OS; k++) begin
            if (variant == 0) send_beat(b != 0 ? iq(A, A) : iq(-A, -A));
            else              send_beat(b != 0 ? iq(A, -A) : iq(-32768, -32768));
        end
    endtask

    task automatic send_word(input logic [7:0] w, input int variant);
        for (int k = SL-1; k >= 0; k--) send_bit(int'(w[k]), variant);
    endtask

    task automatic send_ramp(input int n);
        for (int k = 1; k <= n; k++) send_beat(iq(0, k));
    endtask

    task automatic obs_reset();
        beat_no = 0; sync_seen = 0; sync_beat = -1; tv_seen = 0; tl_seen = 0; tl_at = -1;
        first_td = '0; last_td = '0;
    endtask

    initial begin
        logic [7:0] fw;
        reset = 1'b1; clear = 1'b0; bus.in_tvalid = 1'b0; bus.in_tdata = '0;
        model_clear(0);
        obs_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rx_state", rx_state, 0);
        chk("reset_sync", sync_pulse, 0);
        chk("reset_slip", slip_count, 0);
        chk("reset_err", err_count, 0);
        chk("reset_tvalid", bus.out_tvalid, 0);
        chk("reset_tdata", bus.out_tdata, 0);
        reset = 1'b0;

        // Aligned preamble then framed capture of ramp data
        send_bit(0, 0); send_bit(0, 0);
        send_word(SW, 0);
        chk("aligned_sync_beat", sync_beat, 10*OS);
        chk("aligned_err", err_count, 0);
        send_ramp(NIDLE + NCAPT);
        chk("cap_count", tv_seen, 8);
        chk("cap_tlast_count", tl_seen, 1);
        chk("cap_tlast_pos", tl_at, 8);
        chk("cap_first", first_td, 17);
        chk("cap_last", last_td, 24);
        chk("cap_end_state", rx_state, 0);
        chk("aligned_no_slip", slip_count, 0);

        // One bit error is still accepted
        cycle(1'b0, '0, 1'b1);
        obs_reset();
        send_bit(0, 0); send_bit(0, 0);
        send_word(SW ^ 8'h10, 0);
        chk("err1_sync", sync_seen, 1);
        chk("err1_err", err_count, 1);
        send_ramp(NIDLE + NCAPT);
        chk("err1_cap_count", tv_seen, 8);

        // Two bit errors never match, leading to the first slip
        cycle(1'b0, '0, 1'b1);
        obs_reset();
        fw = SW ^ 8'h81;
        for (int k = 0; k < SPER; k++) send_bit(int'(fw[7 - (k % 8)]), 0);
        chk("err2_no_sync", sync_seen, 0);
        chk("err2_state_slip", rx_state, 1);
        chk("err2_slip_count", slip_count, 1);
        chk("err2_err", err_count, 6);

        // Half-bit misalignment: two quarter-bit slips realign
        cycle(1'b0, '0, 1'b1);
        obs_reset();
        for (int k = 0; k < OS/2; k++) send_beat(iq(0, 0));
        for (int k = 0; k < 26; k++) send_bit((k % 2 == 0) ? 1 : 0, 0);
        send_word(SW, 0);
        chk("misalign_sync", sync_seen, 1);
        chk("misalign_slips", slip_count, 3);
        send_ramp(NIDLE + NCAPT);
        chk("misalign_cap_first", first_td, 17);
        chk("misalign_cap_count", tv_seen, 8);

        // Abort on capture beat 4
        cycle(1'b0, '0, 1'b1);
        obs_reset();
        send_bit(0, 0); send_bit(0, 0);
        send_word(SW, 0);
        send_ramp(NIDLE + 3);
        cycle(1'b1, iq(0, 99), 1'b1);
        chk("abort_tvalid", bus.out_tvalid, 0);
        chk("abort_tlast", bus.out_tlast, 0);
        chk("abort_state", rx_state, 0);
        chk("abort_slips", slip_count, 3);
        chk("abort_cap_count", tv_seen, 3);
        chk("abort_no_tlast", tl_seen, 0);
        send_ramp(5);

        // Zero-sum ones and full-scale negative zeros
        cycle(1'b0, '0, 1'b1);
        obs_reset();
        send_bit(0, 1); send_bit(0, 1);
        send_word(SW, 1);
        chk("zero_sum_sync", sync_seen, 1);
        chk("zero_sum_err", err_count, 0);
        send_ramp(NIDLE + NCAPT);

        // Random noise against the model
        cycle(1'b0, '0, 1'b1);
        obs_reset();
        for (int k = 0; k < 3000; k++) send_beat($urandom);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
